// File: rtl/decode_issue_stage.sv
// ARM decode/issue stage: control decode, bypassed register-file read, condition
// check, RAW/flag hazard stall and a valid/ready ID/EX pipeline register.

module decode_control_unit #(
  parameter int CMD_W = 4
) (
  input  logic [1:0]       mode_i,
  input  logic [3:0]       opcode_i,
  input  logic             s_i,
  input  logic             imm_i,
  output logic [CMD_W-1:0] cmd_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             wb_en_o,
  output logic             imm_o,
  output logic             branch_o,
  output logic             status_we_o
);

  always_comb begin
    cmd_o       = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    wb_en_o     = 1'b0;
    imm_o       = 1'b0;
    branch_o    = 1'b0;
    status_we_o = 1'b0;
    case (mode_i)
      2'b00: begin
        imm_o       = imm_i;
        wb_en_o     = 1'b1;
        status_we_o = s_i;
        case (opcode_i)
          4'b1101: cmd_o = CMD_W'(4'b0001);  // MOV
          4'b1111: cmd_o = CMD_W'(4'b1001);  // MVN
          4'b0100: cmd_o = CMD_W'(4'b0010);  // ADD
          4'b0101: cmd_o = CMD_W'(4'b0011);  // ADC
          4'b0010: cmd_o = CMD_W'(4'b0100);  // SUB
          4'b0110: cmd_o = CMD_W'(4'b0101);  // SBC
          4'b0000: cmd_o = CMD_W'(4'b0110);  // AND
          4'b1100: cmd_o = CMD_W'(4'b0111);  // ORR
          4'b0001: cmd_o = CMD_W'(4'b1000);  // EOR
          4'b1010: begin                     // CMP: flags only
            cmd_o   = CMD_W'(4'b0100);
            wb_en_o = 1'b0;
          end
          4'b1000: begin                     // TST: flags only
            cmd_o   = CMD_W'(4'b0110);
            wb_en_o = 1'b0;
          end
          default: begin                     // unsupported opcode decodes as a no-op
            wb_en_o     = 1'b0;
            status_we_o = 1'b0;
          end
        endcase
      end
      2'b01: begin                           // LDR (S=1) / STR (S=0), address = base + offset
        imm_o       = imm_i;
        cmd_o       = CMD_W'(4'b0010);
        mem_read_o  = s_i;
        wb_en_o     = s_i;
        mem_write_o = ~s_i;
      end
      2'b10: begin
        imm_o    = imm_i;
        branch_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

module decode_issue_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_COUNT   = 16,
  parameter int CMD_W       = 4,
  parameter int HAZARD_MODE = 0,
  localparam int RA_W       = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [31:0]       instr_in,
  input  logic [3:0]        status_in,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_wb_en,
  input  logic              ex_mem_read,
  input  logic              ex_status_we,
  input  logic [RA_W-1:0]   ex_dest,
  input  logic              mem_wb_en,
  input  logic [RA_W-1:0]   mem_dest,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [CMD_W-1:0]  out_cmd,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_wb_en,
  output logic              out_imm,
  output logic              out_branch,
  output logic              out_status_we,
  output logic [DATA_W-1:0] out_val1,
  output logic [DATA_W-1:0] out_val2,
  output logic [RA_W-1:0]   out_src1,
  output logic [RA_W-1:0]   out_src2,
  output logic [RA_W-1:0]   out_dest,
  output logic              out_two_src,
  output logic [23:0]       out_signed_imm,
  output logic [11:0]       out_shift_operand,
  output logic              hazard_stall
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [CMD_W-1:0]  cmd;
    logic              mem_read;
    logic              mem_write;
    logic              wb_en;
    logic              imm;
    logic              branch;
    logic              status_we;
    logic              two_src;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [RA_W-1:0]   src1;
    logic [RA_W-1:0]   src2;
    logic [RA_W-1:0]   dest;
    logic [23:0]       signed_imm;
    logic [11:0]       shift_operand;
  } idex_t;

  logic [REG_COUNT-1:0][DATA_W-1:0] rf_q;

  logic [CMD_W-1:0]  cu_cmd;
  logic              cu_mem_read, cu_mem_write, cu_wb_en, cu_imm, cu_branch, cu_status_we;
  logic [3:0]        cond;
  logic              cond_pass;
  logic              flag_n, flag_z, flag_c, flag_v;
  logic [RA_W-1:0]   src1, src2, dest;
  logic              two_src;
  logic [DATA_W-1:0] rd1, rd2;
  logic              raw_ex, raw_mem, data_stall, flag_stall, stall, advance;
  idex_t             dec;
  idex_t             idex_q, idex_d;
  logic              valid_q, valid_d;

  decode_control_unit #(.CMD_W(CMD_W)) u_cu (
    .mode_i      (instr_in[27:26]),
    .opcode_i    (instr_in[24:21]),
    .s_i         (instr_in[20]),
    .imm_i       (instr_in[25]),
    .cmd_o       (cu_cmd),
    .mem_read_o  (cu_mem_read),
    .mem_write_o (cu_mem_write),
    .wb_en_o     (cu_wb_en),
    .imm_o       (cu_imm),
    .branch_o    (cu_branch),
    .status_we_o (cu_status_we)
  );

  // Register file; reads below bypass a same-cycle write so the new value is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rf_q <= '0;
    else if (wb_en) rf_q[wb_addr] <= wb_data;
  end

  assign src1    = RA_W'(instr_in[19:16]);
  assign src2    = cu_mem_write ? RA_W'(instr_in[15:12]) : RA_W'(instr_in[3:0]);
  assign dest    = RA_W'(instr_in[15:12]);
  assign two_src = ~instr_in[25] | cu_mem_write;

  assign rd1 = (wb_en && wb_addr == src1) ? wb_data : rf_q[src1];
  assign rd2 = (wb_en && wb_addr == src2) ? wb_data : rf_q[src2];

  assign cond = instr_in[31:28];
  assign {flag_n, flag_z, flag_c, flag_v} = status_in;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Hazards use the raw decode: a condition-failed instruction still stalls.
  assign raw_ex  = ex_wb_en  && (ex_dest  == src1 || (two_src && ex_dest  == src2));
  assign raw_mem = mem_wb_en && (mem_dest == src1 || (two_src && mem_dest == src2));

  assign data_stall = (HAZARD_MODE == 0) ? (raw_ex | raw_mem) : (raw_ex & ex_mem_read);
  assign flag_stall = (cond != 4'b1110) && ex_status_we;
  assign stall      = data_stall | flag_stall;

  assign hazard_stall = in_valid && stall;
  assign advance      = out_ready || !valid_q;
  assign in_ready     = flush || (advance && !stall);

  always_comb begin
    dec               = '0;
    dec.pc            = pc_in;
    dec.val1          = rd1;
    dec.val2          = rd2;
    dec.src1          = src1;
    dec.src2          = src2;
    dec.dest          = dest;
    dec.signed_imm    = instr_in[23:0];
    dec.shift_operand = instr_in[11:0];
    if (cond_pass) begin
      dec.cmd       = cu_cmd;
      dec.mem_read  = cu_mem_read;
      dec.mem_write = cu_mem_write;
      dec.wb_en     = cu_wb_en;
      dec.imm       = cu_imm;
      dec.branch    = cu_branch;
      dec.status_we = cu_status_we;
      dec.two_src   = two_src;
    end
  end

  // Flushed slots and bubbles are loaded as all-zero so nothing stale leaks downstream.
  always_comb begin
    valid_d = valid_q;
    idex_d  = idex_q;
    if (flush) begin
      valid_d = 1'b0;
      idex_d  = '0;
    end else if (advance) begin
      valid_d = in_valid && !stall;
      idex_d  = (in_valid && !stall) ? dec : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_pc            = idex_q.pc;
  assign out_cmd           = idex_q.cmd;
  assign out_mem_read      = idex_q.mem_read;
  assign out_mem_write     = idex_q.mem_write;
  assign out_wb_en         = idex_q.wb_en;
  assign out_imm           = idex_q.imm;
  assign out_branch        = idex_q.branch;
  assign out_status_we     = idex_q.status_we;
  assign out_two_src       = idex_q.two_src;
  assign out_val1          = idex_q.val1;
  assign out_val2          = idex_q.val2;
  assign out_src1          = idex_q.src1;
  assign out_src2          = idex_q.src2;
  assign out_dest          = idex_q.dest;
  assign out_signed_imm    = idex_q.signed_imm;
  assign out_shift_operand = idex_q.shift_operand;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: both hazard modes run side by side on shared stimulus
// and are checked every cycle against an instruction-level reference model.

module tb_decode_issue_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cmd;
    logic        mr, mw, wb, imm, br, swe, two;
    logic [31:0] v1, v2;
    logic [3:0]  s1, s2, dst;
    logic [23:0] simm;
    logic [11:0] shop;
  } bun_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready, wb_en, ex_wb_en, ex_mem_read, ex_status_we, mem_wb_en;
  logic [31:0] pc_in, instr_in, wb_data;
  logic [3:0]  status_in, wb_addr, ex_dest, mem_dest;

  logic        o_in_ready [2], o_stall [2], o_valid [2];
  logic [31:0] o_pc [2], o_v1 [2], o_v2 [2];
  logic [3:0]  o_cmd [2], o_s1 [2], o_s2 [2], o_dst [2];
  logic        o_mr [2], o_mw [2], o_wb [2], o_imm [2], o_br [2], o_swe [2], o_two [2];
  logic [23:0] o_simm [2];
  logic [11:0] o_shop [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mrf [16];
  bit          mv [2];
  bun_t        mb [2];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    decode_issue_stage #(.HAZARD_MODE(m)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_in_ready[m]),
      .pc_in(pc_in), .instr_in(instr_in), .status_in(status_in),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .ex_status_we(ex_status_we), .ex_dest(ex_dest),
      .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .flush(flush),
      .out_valid(o_valid[m]), .out_ready(out_ready), .out_pc(o_pc[m]), .out_cmd(o_cmd[m]),
      .out_mem_read(o_mr[m]), .out_mem_write(o_mw[m]), .out_wb_en(o_wb[m]), .out_imm(o_imm[m]),
      .out_branch(o_br[m]), .out_status_we(o_swe[m]), .out_val1(o_v1[m]), .out_val2(o_v2[m]),
      .out_src1(o_s1[m]), .out_src2(o_s2[m]), .out_dest(o_dst[m]), .out_two_src(o_two[m]),
      .out_signed_imm(o_simm[m]), .out_shift_operand(o_shop[m]), .hazard_stall(o_stall[m])
    );
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bun_t observed(input int m);
    bun_t b;
    b.pc = o_pc[m];  b.cmd = o_cmd[m];
    b.mr = o_mr[m];  b.mw = o_mw[m];  b.wb = o_wb[m]; b.imm = o_imm[m];
    b.br = o_br[m];  b.swe = o_swe[m]; b.two = o_two[m];
    b.v1 = o_v1[m];  b.v2 = o_v2[m];
    b.s1 = o_s1[m];  b.s2 = o_s2[m];  b.dst = o_dst[m];
    b.simm = o_simm[m]; b.shop = o_shop[m];
    return b;
  endfunction

  // ARM conditions come in complementary pairs: cond[3:1] picks the test, cond[0] inverts.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, r;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic logic [31:0] rd(input logic [3:0] a);
    return (wb_en && wb_addr == a) ? wb_data : mrf[a];
  endfunction

  // Unmasked decode of the instruction on the inputs (used for hazards).
  function automatic bun_t decode_raw();
    int dp_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};
    bun_t b = '0;
    logic [3:0] op = instr_in[24:21];
    bit s = instr_in[20];
    case (instr_in[27:26])
      2'b00: begin
        b.imm = instr_in[25];
        if (dp_cmd[op] >= 0) begin
          b.cmd = dp_cmd[op][3:0];
          b.wb  = !(op == 4'd8 || op == 4'd10);
          b.swe = s;
        end
      end
      2'b01: begin b.imm = instr_in[25]; b.cmd = 4'd2; b.mr = s; b.wb = s; b.mw = !s; end
      2'b10: begin b.imm = instr_in[25]; b.br = 1'b1; end
      default: ;
    endcase
    b.s1   = instr_in[19:16];
    b.s2   = b.mw ? instr_in[15:12] : instr_in[3:0];
    b.dst  = instr_in[15:12];
    b.two  = !instr_in[25] || b.mw;
    b.pc   = pc_in;
    b.v1   = rd(b.s1);
    b.v2   = rd(b.s2);
    b.simm = instr_in[23:0];
    b.shop = instr_in[11:0];
    return b;
  endfunction

  function automatic bit model_stall(input int m, input bun_t r);
    bit rex  = ex_wb_en  && (ex_dest  == r.s1 || (r.two && ex_dest  == r.s2));
    bit rmem = mem_wb_en && (mem_dest == r.s1 || (r.two && mem_dest == r.s2));
    bit d    = (m == 0) ? (rex || rmem) : (rex && ex_mem_read);
    return d || (instr_in[31:28] != 4'hE && ex_status_we);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mrf[i] = '0;
    for (int m = 0; m < 2; m++) begin mv[m] = 1'b0; mb[m] = '0; end
  endtask

  // One clock: combinational checks before the edge, register checks after it.
  task automatic step(input string tag);
    bun_t raw, fin;
    bit st [2];
    bit adv [2];
    #1;
    raw = decode_raw();
    fin = raw;
    if (!cond_ok(instr_in[31:28], status_in)) begin
      fin.cmd = '0; fin.mr = 0; fin.mw = 0; fin.wb = 0; fin.imm = 0; fin.br = 0; fin.swe = 0; fin.two = 0;
    end
    for (int m = 0; m < 2; m++) begin
      st[m]  = model_stall(m, raw);
      adv[m] = out_ready || !mv[m];
      chk($sformatf("%s/m%0d/hazard_stall", tag, m), o_stall[m], in_valid && st[m]);
      chk($sformatf("%s/m%0d/in_ready", tag, m), o_in_ready[m], flush || (adv[m] && !st[m]));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (flush) begin
        mv[m] = 1'b0; mb[m] = '0;
      end else if (adv[m]) begin
        mv[m] = in_valid && !st[m];
        mb[m] = mv[m] ? fin : '0;
      end
    end
    if (wb_en) mrf[wb_addr] = wb_data;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s/m%0d/out_valid", tag, m), o_valid[m], mv[m]);
      chk($sformatf("%s/m%0d/bundle", tag, m), observed(m), mb[m]);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 1; wb_en = 0; ex_wb_en = 0; ex_mem_read = 0;
    ex_status_we = 0; mem_wb_en = 0; pc_in = '0; instr_in = 32'hE1A00000; wb_data = '0;
    status_in = '0; wb_addr = '0; ex_dest = '0; mem_dest = '0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset/m%0d/out_valid", m), o_valid[m], 1'b0);
      chk($sformatf("reset/m%0d/bundle", m), observed(m), '0);
    end
    rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) chk($sformatf("reset/m%0d/in_ready", m), o_in_ready[m], 1'b1);
    @(negedge clk);

    // Write R2=5, R3=7, then ADD R1,R2,R3
    wb_en = 1; wb_addr = 4'd2; wb_data = 32'd5; step("wr_r2");
    wb_addr = 4'd3; wb_data = 32'd7;            step("wr_r3");
    wb_en = 0; in_valid = 1; instr_in = 32'hE0821003; pc_in = 32'h100; step("add");
    chk("add/val1", o_v1[1], 32'd5);
    chk("add/val2", o_v2[1], 32'd7);
    chk("add/dest", o_dst[1], 4'd1);
    chk("add/wb_en", o_wb[1], 1'b1);
    chk("add/two_src", o_two[1], 1'b1);
    wb_en = 1; wb_addr = 4'd2; wb_data = 32'd9; step("add_bypass");
    chk("add_bypass/val1", o_v1[1], 32'd9);
    wb_en = 0; in_valid = 0; step("gap0");

    // Load-use against EX
    ex_wb_en = 1; ex_mem_read = 1; ex_dest = 4'd4; in_valid = 1; instr_in = 32'hE0845002;
    #1;
    chk("lduse/hazard_stall", o_stall[1], 1'b1);
    chk("lduse/in_ready", o_in_ready[1], 1'b0);
    step("lduse");
    chk("lduse/out_valid", o_valid[1], 1'b0);
    ex_wb_en = 0; ex_mem_read = 0; step("lduse_clear");
    chk("lduse_clear/out_valid", o_valid[1], 1'b1);
    chk("lduse_clear/dest", o_dst[1], 4'd5);
    in_valid = 0; step("gap1");

    // RAW against MEM: only the no-forwarding variant stalls
    mem_wb_en = 1; mem_dest = 4'd2; in_valid = 1; instr_in = 32'hE0821003;
    #1;
    chk("rawmem/mode0_stall", o_stall[0], 1'b1);
    chk("rawmem/mode1_stall", o_stall[1], 1'b0);
    step("rawmem");
    mem_wb_en = 0; in_valid = 0; step("gap2");

    // Condition codes
    status_in = 4'b0000; in_valid = 1; instr_in = 32'h00821003; step("eq_fail");
    chk("eq_fail/out_valid", o_valid[1], 1'b1);
    chk("eq_fail/controls", {o_cmd[1], o_mr[1], o_mw[1], o_wb[1], o_imm[1], o_br[1], o_swe[1], o_two[1]}, '0);
    status_in = 4'b0100; step("eq_pass");
    chk("eq_pass/cmd", o_cmd[1], 4'd2);
    chk("eq_pass/wb_en", o_wb[1], 1'b1);
    ex_status_we = 1;
    #1;
    chk("flaghaz/hazard_stall", o_stall[1], 1'b1);
    step("flaghaz0"); step("flaghaz1");
    chk("flaghaz/out_valid", o_valid[1], 1'b0);
    ex_status_we = 0; step("flaghaz_clear");
    chk("flaghaz_clear/out_valid", o_valid[1], 1'b1);
    in_valid = 0; status_in = 4'b0000; step("gap3");

    // Backpressure then flush
    in_valid = 1; instr_in = 32'hE0821003; pc_in = 32'h200; step("bp_fill");
    out_ready = 0; pc_in = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp/in_ready", o_in_ready[1], 1'b0);
      step("bp");
      chk("bp/out_pc", o_pc[1], 32'h200);
    end
    flush = 1;
    #1;
    chk("flush/in_ready", o_in_ready[1], 1'b1);
    step("flush");
    chk("flush/out_valid", o_valid[1], 1'b0);
    idle(); step("gap4");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom();
      ins[31:28] = ($urandom_range(0, 9) < 6) ? 4'hE : 4'($urandom_range(0, 15));
      ins[19:16] = 4'($urandom_range(0, 7));
      ins[15:12] = 4'($urandom_range(0, 7));
      ins[3:0]   = 4'($urandom_range(0, 7));
      instr_in     = ins;
      pc_in        = $urandom();
      status_in    = 4'($urandom_range(0, 15));
      in_valid     = ($urandom_range(0, 4) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 11) == 0);
      wb_en        = ($urandom_range(0, 1) != 0);
      wb_addr      = 4'($urandom_range(0, 7));
      wb_data      = $urandom();
      ex_wb_en     = ($urandom_range(0, 3) == 0);
      ex_mem_read  = ($urandom_range(0, 1) != 0);
      ex_status_we = ($urandom_range(0, 6) == 0);
      ex_dest      = 4'($urandom_range(0, 7));
      mem_wb_en    = ($urandom_range(0, 3) == 0);
      mem_dest     = 4'($urandom_range(0, 7));
      step("rand");
    end

    // Asynchronous reset between edges
    idle(); in_valid = 1; instr_in = 32'hE0821003; pc_in = 32'h300;
    wb_en = 1; wb_addr = 4'd3; wb_data = 32'h55; step("pre_rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("async_rst/m%0d/out_valid", m), o_valid[m], 1'b0);
      chk($sformatf("async_rst/m%0d/bundle", m), observed(m), '0);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(); in_valid = 1; instr_in = 32'hE0821003; pc_in = 32'h400; step("post_rst");
    chk("post_rst/val1", o_v1[1], 32'd0);
    chk("post_rst/val2", o_v2[1], 32'd0);
    chk("post_rst/out_valid", o_valid[1], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
